// File: rtl/uart_cfg_pkg.sv
// Shared UART configuration package.
// Holds the default generator parameters and the oversample-ratio helpers
// used by baud_tick_gen. No ports; imported with uart_cfg_pkg::*.
package uart_cfg_pkg;

  localparam int unsigned DEFAULT_DIV_W  = 32'd16;
  localparam int unsigned DEFAULT_FRAC_W = 32'd4;
  localparam int unsigned DEFAULT_OVS    = 32'd16;

  // True when v is a power of two and at least 2.
  function automatic bit ovs_is_pow2(input int unsigned v);
    return (v >= 32'd2) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  // Oversample ratio actually built: an illegal ratio falls back to the default
  // so the rx/tx tick relationship always stays well defined.
  function automatic int unsigned ovs_checked(input int unsigned v);
    return ovs_is_pow2(v) ? v : DEFAULT_OVS;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Fractional baud-rate tick generator.
// Produces a one-cycle oversample tick (rx_tick_o) whose average period is
// div + frac/2^FRAC_W clock cycles, and a bit tick (tx_tick_o) on every
// OVS-th oversample tick. Configuration goes through a shadow register that
// is only made active at a period boundary, so a running period is never cut.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   en_i           generator enable; low clears the phase and stops ticks
//   cfg_we_i       one-cycle strobe loading baud_div_i/baud_frac_i into shadow
//   baud_div_i     integer oversample period in clock cycles
//   baud_frac_i    fractional period, units of 2^-FRAC_W cycle
//   sync_i         phase restart (rx start-bit alignment)
//   rx_tick_o      one-cycle oversample tick (registered)
//   tx_tick_o      one-cycle bit tick, coincident with every OVS-th rx tick
//   cfg_pending_o  shadow config written but not yet active
module baud_tick_gen
  import uart_cfg_pkg::*;
#(
  parameter int unsigned DIV_W  = DEFAULT_DIV_W,
  parameter int unsigned FRAC_W = DEFAULT_FRAC_W,
  parameter int unsigned OVS    = DEFAULT_OVS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              cfg_we_i,
  input  logic [DIV_W-1:0]  baud_div_i,
  input  logic [FRAC_W-1:0] baud_frac_i,
  input  logic              sync_i,
  output logic              rx_tick_o,
  output logic              tx_tick_o,
  output logic              cfg_pending_o
);

  localparam int unsigned OVS_EFF = ovs_checked(OVS);
  localparam int unsigned OVS_W   = $clog2(OVS_EFF);
  // One extra bit so that L = (2^DIV_W - 1) + carry cannot overflow.
  localparam int unsigned CNT_W   = DIV_W + 32'd1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{DIV_W{1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0]  DIV_ZERO  = {DIV_W{1'b0}};
  localparam logic [FRAC_W-1:0] FRAC_ZERO = {FRAC_W{1'b0}};
  localparam logic [OVS_W-1:0]  OVS_ZERO  = {OVS_W{1'b0}};
  localparam logic [OVS_W-1:0]  OVS_ONE   = OVS_W'(32'd1);
  localparam logic [OVS_W-1:0]  OVS_LAST  = OVS_W'(OVS_EFF - 32'd1);

  // Phase state
  logic [CNT_W-1:0]  cnt_r;
  logic [FRAC_W-1:0] acc_r;
  logic              carry_r;
  logic [OVS_W-1:0]  ovs_cnt_r;

  // Configuration state
  logic [DIV_W-1:0]  act_div_r;
  logic [FRAC_W-1:0] act_frac_r;
  logic [DIV_W-1:0]  sh_div_r;
  logic [FRAC_W-1:0] sh_frac_r;
  logic              pending_r;

  // Output registers
  logic              rx_tick_r;
  logic              tx_tick_r;

  // Combinational decode
  logic [CNT_W-1:0]  period_s;
  logic [FRAC_W:0]   acc_sum_s;
  logic              div_zero_s;
  logic              restart_s;
  logic              due_s;
  logic              ovs_wrap_s;
  logic              apply_s;

  // Period length, tick decision and shadow-apply decision for this cycle.
  always_comb begin
    period_s   = {1'b0, act_div_r} + {{DIV_W{1'b0}}, carry_r};
    acc_sum_s  = {1'b0, acc_r} + {1'b0, act_frac_r};
    div_zero_s = (act_div_r == DIV_ZERO);
    // Disabled, resynchronised or unconfigured: phase is held at zero.
    restart_s  = !en_i || sync_i || div_zero_s;
    // '>=' rather than '==' so a corrupted count still ends the period.
    due_s      = !restart_s && (cnt_r >= (period_s - CNT_ONE));
    ovs_wrap_s = (ovs_cnt_r == OVS_LAST);
    // The shadow goes live only at a period boundary or while idle.
    apply_s    = pending_r && (due_s || !en_i || div_zero_s);
  end

  // Period counter, fractional accumulator and oversample counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_r     <= CNT_ZERO;
      acc_r     <= FRAC_ZERO;
      carry_r   <= 1'b0;
      ovs_cnt_r <= OVS_ZERO;
    end else if (restart_s) begin
      cnt_r     <= CNT_ZERO;
      acc_r     <= FRAC_ZERO;
      carry_r   <= 1'b0;
      ovs_cnt_r <= OVS_ZERO;
    end else if (due_s) begin
      cnt_r     <= CNT_ZERO;
      acc_r     <= acc_sum_s[FRAC_W-1:0];
      carry_r   <= acc_sum_s[FRAC_W];
      ovs_cnt_r <= ovs_wrap_s ? OVS_ZERO : (ovs_cnt_r + OVS_ONE);
    end else begin
      cnt_r     <= cnt_r + CNT_ONE;
    end
  end

  // Registered tick outputs; due_s already excludes disable and sync.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_tick_r <= 1'b0;
      tx_tick_r <= 1'b0;
    end else begin
      rx_tick_r <= due_s;
      tx_tick_r <= due_s && ovs_wrap_s;
    end
  end

  // Active configuration: takes the shadow contents when apply_s fires.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      act_div_r  <= DIV_ZERO;
      act_frac_r <= FRAC_ZERO;
    end else if (apply_s) begin
      act_div_r  <= sh_div_r;
      act_frac_r <= sh_frac_r;
    end else begin
      act_div_r  <= act_div_r;
      act_frac_r <= act_frac_r;
    end
  end

  // Shadow register and pending flag; a coincident write wins over the clear
  // so the freshly written value is still waiting after the old one applies.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sh_div_r  <= DIV_ZERO;
      sh_frac_r <= FRAC_ZERO;
      pending_r <= 1'b0;
    end else if (cfg_we_i) begin
      sh_div_r  <= baud_div_i;
      sh_frac_r <= baud_frac_i;
      pending_r <= 1'b1;
    end else if (apply_s) begin
      sh_div_r  <= sh_div_r;
      sh_frac_r <= sh_frac_r;
      pending_r <= 1'b0;
    end else begin
      sh_div_r  <= sh_div_r;
      sh_frac_r <= sh_frac_r;
      pending_r <= pending_r;
    end
  end

  assign rx_tick_o     = rx_tick_r;
  assign tx_tick_o     = tx_tick_r;
  assign cfg_pending_o = pending_r;

endmodule
